seg_dynamic: RTL and testbench
==============================

Name: seg_dynamic

Overview:
- Parametrised multiplexed seven-segment driver, successor to the single-pattern static display block.
- Time-multiplexes DIGITS hex digits onto a shared seg bus, one digit per slot, with a dead-time interval between slots to suppress ghosting.
- Per-digit decimal point and blanking.
- Tear-free double-buffered load: new values take effect only at a frame boundary.
- Sits between system/application logic and the board's common-anode digit/segment pins.

Parameters:
DIGITS, 6, number of digits scanned (1..8)
DIGIT_CYCLES, 50000, sys_clk cycles per digit slot (1 ms at 50 MHz); must be ≥ 2
DEAD_CYCLES, 500, cycles at the start of each slot with all digits off; must be < DIGIT_CYCLES
SEL_ACTIVE_LOW, 1, 1: sel bit 0 enables a digit; 0: sel bit 1 enables a digit
SEG_ACTIVE_LOW, 1, 1: seg bit 0 lights a segment; 0: all seg outputs inverted

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst  in  1  synchronous active-high reset
load  in  1  single-cycle strobe; captures data/dp/blank
data  in  4*DIGITS  hex nibbles; digit i = data[4i+3:4i]; digit 0 is rightmost
dp  in  DIGITS  decimal point per digit, 1 = lit
blank  in  DIGITS  per-digit blank, 1 = digit dark
busy  out  1  a captured load is pending its frame boundary
frame_done  out  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0
sel  out  DIGITS  digit enables
seg  out  8  segments; seg[7] = dp, seg[6:0] = g..a

Behaviour:
- Clocking and reset: one clock, sys_clk; reset sys_rst is synchronous and active-high.
- Reset values:
  - sel all inactive (6'h3F with defaults); seg all off (8'hFF with defaults).
  - busy=0, frame_done=0.
  - Display registers: data=0, dp=0, blank all 1s, so the display is dark until the first load.
  - Digit index=0, slot counter=0, FSM=DEAD.
- FSM per slot:
  - DEAD: DEAD_CYCLES cycles, sel inactive, seg off.
  - ON: DIGIT_CYCLES−DEAD_CYCLES cycles, current digit shown.
  - After ON, the index increments (wrapping DIGITS-1 → 0) and the FSM returns to DEAD.
  - If DEAD_CYCLES=0, DEAD is skipped.
- Outputs: sel and seg are registered, one cycle behind the FSM state and index.
- ON-slot drive:
  - sel asserts only bit idx.
  - seg = hex pattern of the nibble with seg[7] lit if dp[idx]. Active-low codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, B=83, C=C6, D=A1, E=86, F=8E (hex, dp bit off).
- Blanked digit: during its ON slot, sel stays inactive and seg stays off. Slot timing is unchanged.
- frame_done is asserted in the cycle the index wraps to 0 (the frame boundary).
- Load handshake:
  - A load captures inputs into pending registers and sets busy.
  - At the next frame boundary, pending values are copied into the display registers and busy clears.
  - Load while busy: pending is overwritten (last wins).
  - Load in the same cycle as the frame boundary: inputs are written directly into the display registers and busy remains 0.
- Reset mid-slot: the next cycle shows reset values, and any pending load is discarded.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: the effective blank of digit i is blank[i] OR (all nibbles at positions ≥ i are zero, and i ≠ 0). Digit 0 always shows.
- Undefined: only the blank input controls blanking.

Decomposition:
- Package seg_pkg holds:
  - the 16 SEG_x active-low encodings and SEG_OFF=8'hFF;
  - the FSM state encoding (DEAD, ON);
  - a SEL_OFF helper.
- One sub-module, seg_hex_decode: combinational 4-bit nibble + dp → 8-bit active-low pattern. Polarity inversion is applied in the parent.

Test Plan (DIGITS=6, DIGIT_CYCLES=10, DEAD_CYCLES=2, other parameters default):
1. Reset, then load data=24'h012345, dp=0, blank=0. After the first frame_done, slot 0 ON shows sel=6'b111110, seg=8'h92; slot 5 ON shows sel=6'b011111, seg=8'hC0.
2. Free-run timing: each slot gives 2 cycles with sel=6'h3F, then 8 cycles with one sel bit low. frame_done pulses every 60 cycles, exactly one cycle wide.
3. Load data=24'hFFFFFF mid-frame. busy goes to 1 the next cycle; the display keeps its old values until frame_done; busy returns to 0 at frame_done; from the next frame, slots show 8'h8E.
4. Set blank=6'b000100 and dp=6'b000001. Slot 2 shows sel=6'h3F, seg=8'hFF for all 10 cycles. Slot 0 has seg[7]=0.
5. Assert sys_rst during an ON slot. The next cycle shows sel=6'h3F, seg=8'hFF, busy=0, and a prior pending load is lost.
6. With SEG_LEADING_ZERO_BLANK_EN defined, load data=24'h000A05. Digits 5, 4 and 3 stay dark; digit 2 shows 8'h88; digit 1 shows 8'hC0; digit 0 shows 8'h92.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment driver: active-low hex
// glyphs, scan FSM states and the idle digit-enable helper.
package seg_pkg;

  localparam logic [7:0] SEG_0   = 8'hC0;
  localparam logic [7:0] SEG_1   = 8'hF9;
  localparam logic [7:0] SEG_2   = 8'hA4;
  localparam logic [7:0] SEG_3   = 8'hB0;
  localparam logic [7:0] SEG_4   = 8'h99;
  localparam logic [7:0] SEG_5   = 8'h92;
  localparam logic [7:0] SEG_6   = 8'h82;
  localparam logic [7:0] SEG_7   = 8'hF8;
  localparam logic [7:0] SEG_8   = 8'h80;
  localparam logic [7:0] SEG_9   = 8'h90;
  localparam logic [7:0] SEG_A   = 8'h88;
  localparam logic [7:0] SEG_B   = 8'h83;
  localparam logic [7:0] SEG_C   = 8'hC6;
  localparam logic [7:0] SEG_D   = 8'hA1;
  localparam logic [7:0] SEG_E   = 8'h86;
  localparam logic [7:0] SEG_F   = 8'h8E;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  typedef enum logic {
    DEAD = 1'b0,
    ON   = 1'b1
  } scan_state_e;

  // Idle level of the digit enables for up to 8 digits; callers slice to width.
  function automatic logic [7:0] sel_off(input logic active_low);
    return {8{active_low}};
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Nibble plus decimal point to active-low seven-segment pattern (seg[7] = dp).
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] pattern
);

  always_comb begin
    pattern = SEG_OFF;
    case (nibble)
      4'h0: pattern = SEG_0;
      4'h1: pattern = SEG_1;
      4'h2: pattern = SEG_2;
      4'h3: pattern = SEG_3;
      4'h4: pattern = SEG_4;
      4'h5: pattern = SEG_5;
      4'h6: pattern = SEG_6;
      4'h7: pattern = SEG_7;
      4'h8: pattern = SEG_8;
      4'h9: pattern = SEG_9;
      4'hA: pattern = SEG_A;
      4'hB: pattern = SEG_B;
      4'hC: pattern = SEG_C;
      4'hD: pattern = SEG_D;
      4'hE: pattern = SEG_E;
      4'hF: pattern = SEG_F;
      default: pattern = SEG_OFF;
    endcase
    if (dp) pattern[7] = 1'b0;
  end

endmodule

// File: rtl/seg_dynamic.sv
// Multiplexed seven-segment scanner with dead time and frame-aligned double buffering.
// Optional SEG_LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 always shows).
module seg_dynamic
  import seg_pkg::*;
#(
  parameter int DIGITS         = 6,
  parameter int DIGIT_CYCLES   = 50000,
  parameter int DEAD_CYCLES    = 500,
  parameter int SEL_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  output logic                  busy,
  output logic                  frame_done,
  output logic [DIGITS-1:0]     sel,
  output logic [7:0]            seg
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(DIGIT_CYCLES);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam scan_state_e      SLOT_START = (DEAD_CYCLES > 0) ? DEAD : ON;
  localparam logic [7:0]        SEL_OFF8  = sel_off(SEL_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] SEL_IDLE  = SEL_OFF8[DIGITS-1:0];
  localparam logic [7:0]        SEG_IDLE  = (SEG_ACTIVE_LOW != 0) ? SEG_OFF : ~SEG_OFF;

  scan_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 wrap;

  logic [4*DIGITS-1:0]  disp_data_q, disp_data_d;
  logic [DIGITS-1:0]    disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]    disp_blank_q, disp_blank_d;
  logic [4*DIGITS-1:0]  pend_data_q, pend_data_d;
  logic [DIGITS-1:0]    pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0]    pend_blank_q, pend_blank_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic [DIGITS-1:0]    sel_q, sel_d;
  logic [7:0]           seg_q, seg_d;

  logic [3:0]           nibbles [DIGITS];
  logic [DIGITS-1:0]    blank_eff;
  logic [DIGITS-1:0]    digit_onehot;
  logic [7:0]           digit_pattern;

  // Slot sequencer: DEAD for DEAD_CYCLES, then ON until the slot ends.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    wrap    = 1'b0;
    case (state_q)
      DEAD: begin
        if (cnt_q == DEAD_LAST) state_d = ON;
      end
      ON: begin
        if (cnt_q == SLOT_LAST) begin
          cnt_d   = '0;
          state_d = SLOT_START;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = SLOT_START;
    endcase
  end

  // A load coinciding with the boundary bypasses the pending buffer.
  always_comb begin
    disp_data_d  = disp_data_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    busy_d       = busy_q;
    frame_done_d = wrap;
    if (wrap && load) begin
      disp_data_d  = data;
      disp_dp_d    = dp;
      disp_blank_d = blank;
      busy_d       = 1'b0;
    end else if (wrap && busy_q) begin
      disp_data_d  = pend_data_q;
      disp_dp_d    = pend_dp_q;
      disp_blank_d = pend_blank_q;
      busy_d       = 1'b0;
    end else if (load) begin
      pend_data_d  = data;
      pend_dp_d    = dp;
      pend_blank_d = blank;
      busy_d       = 1'b1;
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [DIGITS:0] upper_zero;
  assign upper_zero[DIGITS] = 1'b1;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign nibbles[gi] = disp_data_q[4*gi +: 4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
      assign upper_zero[gi] = (disp_data_q[4*gi +: 4] == 4'h0) & upper_zero[gi+1];
      assign blank_eff[gi]  = disp_blank_q[gi] | (upper_zero[gi] & (gi != 0));
`else
      assign blank_eff[gi]  = disp_blank_q[gi];
`endif
    end
  endgenerate

  assign digit_onehot = DIGITS'(1) << idx_q;

  seg_hex_decode u_decode (
    .nibble  (nibbles[idx_q]),
    .dp      (disp_dp_q[idx_q]),
    .pattern (digit_pattern)
  );

  // Pins are registered from the current state, so they trail the FSM by one cycle.
  always_comb begin
    sel_d = SEL_IDLE;
    seg_d = SEG_IDLE;
    if (state_q == ON && !blank_eff[idx_q]) begin
      sel_d = (SEL_ACTIVE_LOW != 0) ? ~digit_onehot : digit_onehot;
      seg_d = (SEG_ACTIVE_LOW != 0) ? digit_pattern : ~digit_pattern;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= SLOT_START;
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '1;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      sel_q        <= SEL_IDLE;
      seg_q        <= SEG_IDLE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign sel        = sel_q;
  assign seg        = seg_q;

endmodule

// File: tb/tb_seg_dynamic.sv
// Self-checking bench for seg_dynamic (6 digits, 10-cycle slots, 2 dead cycles):
// vector table, corner sequences and random loads against a slot-arithmetic model.
module tb_seg_dynamic;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        load;
  logic [23:0] data;
  logic [5:0]  dp;
  logic [5:0]  blank;
  logic        busy;
  logic        frame_done;
  logic [5:0]  sel;
  logic [7:0]  seg;

  seg_dynamic #(
    .DIGITS       (6),
    .DIGIT_CYCLES (10),
    .DEAD_CYCLES  (2)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .load       (load),
    .data       (data),
    .dp         (dp),
    .blank      (blank),
    .busy       (busy),
    .frame_done (frame_done),
    .sel        (sel),
    .seg        (seg)
  );

  always #5 sys_clk = ~sys_clk;

  logic [7:0] lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference state: k = clock edges since the last reset edge.
  int          k;
  logic [23:0] m_data, p_data;
  logic [5:0]  m_dp, p_dp, m_blank, p_blank;
  logic        m_busy;
  int          checks = 0;
  int          passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (k=%0d, t=%0t)", name, act, exp, k, $time);
  endtask

  function automatic logic digit_dark(input int ix);
    logic dark;
    dark = m_blank[ix];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (ix != 0 && (m_data >> (4 * ix)) == 24'h0) dark = 1'b1;
`endif
    return dark;
  endfunction

  // Pins during FSM cycle t: slot = t/10, first 2 cycles of a slot are dead.
  task automatic model_out(input int t, output logic [5:0] s, output logic [7:0] g);
    int pos;
    int ix;
    pos = t % 10;
    ix  = (t / 10) % 6;
    s = 6'h3F;
    g = 8'hFF;
    if (pos >= 2 && !digit_dark(ix)) begin
      s = 6'h3F ^ (6'd1 << ix);
      g = lut[m_data[4*ix +: 4]];
      if (m_dp[ix]) g[7] = 1'b0;
    end
  endtask

  task automatic step(input logic rst, input logic ld, input logic [23:0] d,
                      input logic [5:0] p, input logic [5:0] b);
    logic [5:0] esel;
    logic [7:0] eseg;
    logic       efd;
    logic       wrap;
    @(negedge sys_clk);
    sys_rst = rst;
    load    = ld;
    data    = d;
    dp      = p;
    blank   = b;
    if (rst) begin
      esel = 6'h3F; eseg = 8'hFF; efd = 1'b0;
      m_data = '0; m_dp = '0; m_blank = '1; m_busy = 1'b0;
      k = -1;
    end else begin
      model_out(k, esel, eseg);
      wrap = (k % 60) == 59;
      efd  = wrap;
      if (wrap && ld) begin
        m_data = d; m_dp = p; m_blank = b; m_busy = 1'b0;
      end else if (wrap && m_busy) begin
        m_data = p_data; m_dp = p_dp; m_blank = p_blank; m_busy = 1'b0;
      end else if (ld) begin
        p_data = d; p_dp = p; p_blank = b; m_busy = 1'b1;
      end
    end
    k++;
    @(posedge sys_clk);
    #1;
    check("sel", 32'(sel), 32'(esel));
    check("seg", 32'(seg), 32'(eseg));
    check("frame_done", 32'(frame_done), 32'(efd));
    check("busy", 32'(busy), 32'(m_busy));
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(1'b0, 1'b0, 24'h0, 6'h0, 6'h0);
  endtask

  task automatic idle_until(input int phase, input int period);
    for (int c = 0; c < 200 && (k % period) != phase; c++) idle(1);
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      idle(1);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) passed++;
    else $display("FAIL frame_timeout: got no frame_done, expected one within 200 cycles");
  endtask

  typedef struct {
    logic [23:0] d;
    logic [5:0]  p;
    logic [5:0]  b;
    logic [47:0] exp;   // {digit5 .. digit0} pattern seen mid-ON
  } vec_t;

  vec_t tbl [6];

`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam logic [7:0] LZ = 8'hFF;
`else
  localparam logic [7:0] LZ = 8'hC0;
`endif

  initial begin
    logic [7:0] eb;
    logic [5:0] es;
    int         ix;
    int         fd_cnt;

    tbl[0] = '{24'h012345, 6'b000000, 6'b000000, {LZ, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92}};
    tbl[1] = '{24'hFFFFFF, 6'b000000, 6'b000000, {6{8'h8E}}};
    tbl[2] = '{24'h012345, 6'b000001, 6'b000100, {LZ, 8'hF9, 8'hA4, 8'hFF, 8'h99, 8'h12}};
    tbl[3] = '{24'h89ABCD, 6'b100000, 6'b000000, {8'h00, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1}};
    tbl[4] = '{24'h6E7000, 6'b000000, 6'b000000, {8'h82, 8'h86, 8'hF8, 8'hC0, 8'hC0, 8'hC0}};
    tbl[5] = '{24'h000A05, 6'b000000, 6'b000000, {LZ, LZ, LZ, 8'h88, 8'hC0, 8'h92}};

    sys_rst = 1'b1; load = 1'b0; data = '0; dp = '0; blank = '0;
    p_data = '0; p_dp = '0; p_blank = '1;
    k = 0;
    repeat (3) step(1'b1, 1'b0, 24'h0, 6'h0, 6'h0);
    idle(70);
    $display("reset: display dark, %0d checks so far", checks);

    for (int v = 0; v < 6; v++) begin
      idle_until(25, 60);
      step(1'b0, 1'b1, tbl[v].d, tbl[v].p, tbl[v].b);
      check("busy_after_load", 32'(busy), 32'd1);
      wait_frame();
      check("busy_at_frame", 32'(busy), 32'd0);
      for (int c = 0; c < 60; c++) begin
        idle(1);
        if (((k - 1) % 10) == 5) begin
          ix = ((k - 1) / 10) % 6;
          eb = tbl[v].exp[8*ix +: 8];
          es = (eb == 8'hFF) ? 6'h3F : (6'h3F ^ (6'd1 << ix));
          check("tbl_seg", 32'(seg), 32'(eb));
          check("tbl_sel", 32'(sel), 32'(es));
        end
      end
      $display("vector %0d: data=%h dp=%b blank=%b", v, tbl[v].d, tbl[v].p, tbl[v].b);
    end

    // frame_done period and width
    wait_frame();
    fd_cnt = 0;
    for (int c = 1; c <= 120; c++) begin
      idle(1);
      if (frame_done === 1'b1) begin
        fd_cnt++;
        check("fd_phase", 32'(c % 60), 32'd0);
      end
    end
    check("fd_count", 32'(fd_cnt), 32'd2);
    $display("frame_done period: %0d pulses in 120 cycles", fd_cnt);

    // load exactly in the boundary cycle goes straight to the display
    idle_until(59, 60);
    step(1'b0, 1'b1, 24'h111111, 6'h0, 6'h0);
    check("boundary_busy", 32'(busy), 32'd0);
    idle(60);
    $display("boundary load: data=111111");

    // back-to-back loads: last one wins
    idle_until(10, 60);
    step(1'b0, 1'b1, 24'h222222, 6'h0, 6'h0);
    idle_until(20, 60);
    step(1'b0, 1'b1, 24'h333333, 6'h3F, 6'h0);
    wait_frame();
    idle(60);
    $display("last-wins load: data=333333");

    // reset during an ON slot discards the pending load
    idle_until(15, 60);
    step(1'b0, 1'b1, 24'h444444, 6'h0, 6'h0);
    idle_until(5, 10);
    step(1'b1, 1'b0, 24'h0, 6'h0, 6'h0);
    check("rst_sel", 32'(sel), 32'h3F);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_busy", 32'(busy), 32'd0);
    idle(130);
    $display("mid-slot reset: pending load dropped");

    // random loads and occasional resets
    for (int r = 0; r < 40; r++) begin
      logic [23:0] rd;
      logic [5:0]  rp, rb;
      idle($urandom_range(1, 90));
      rd = 24'($urandom);
      rp = 6'($urandom);
      rb = 6'($urandom) & 6'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        step(1'b1, 1'b0, 24'h0, 6'h0, 6'h0);
        $display("random %0d: reset", r);
      end else begin
        step(1'b0, 1'b1, rd, rp, rb);
        $display("random %0d: load data=%h dp=%b blank=%b", r, rd, rp, rb);
      end
    end
    idle(130);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
